// File: rtl/vectadd_sysid_ext.sv
// vectadd_sysid_ext: system-ID and housekeeping register slave for the vectadd
// Avalon-MM control interconnect.
//
// Word map (read):
//   0 ID_VALUE   1 TIMESTAMP   2 VERSION   3 CAPS
//   4 UPTIME[31:0] (also latches UPTIME[63:32] into the HI snapshot)
//   5 UPTIME_HI snapshot   6 SCRATCH0   7 SCRATCH1
//
// Writes: word 4 clears the uptime counter, words 6/7 update the enabled
// bytes of an implemented scratch register, everything else is ignored.
// A read and a write in the same cycle perform the read only.
//
// Reads return through a fixed pipeline of READ_LATENCY stages (1..3) with a
// one-cycle readdatavalid strobe; no waitrequest, one new read per cycle.
// NUM_SCRATCH selects how many scratch registers exist (0..2); absent ones
// read as zero.

module vectadd_sysid_ext #(
  parameter logic [31:0] ID_VALUE      = 32'd0,
  parameter logic [31:0] TIMESTAMP     = 32'd1480046161,
  parameter logic [31:0] VERSION       = 32'h0002_0000,
  parameter int          READ_LATENCY  = 1,
  parameter int          NUM_SCRATCH   = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  // Capability word: ASCII "SY" tag, reserved byte, then the build-time
  // configuration so software can discover scratch count and read latency.
  localparam logic [31:0] CAPS = {16'h5359, 8'h00,
                                  4'(NUM_SCRATCH), 4'(READ_LATENCY)};

  localparam logic [2:0] ADDR_ID       = 3'd0;
  localparam logic [2:0] ADDR_STAMP    = 3'd1;
  localparam logic [2:0] ADDR_VERSION  = 3'd2;
  localparam logic [2:0] ADDR_CAPS     = 3'd3;
  localparam logic [2:0] ADDR_UPTIME   = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH0 = 3'd6;
  localparam logic [2:0] ADDR_SCRATCH1 = 3'd7;

  // A simultaneous read wins: the write half of the cycle is dropped.
  logic wr_en;
  assign wr_en = write && !read;

  logic        uptime_rd;
  logic        uptime_clr;
  assign uptime_rd  = read  && (address == ADDR_UPTIME);
  assign uptime_clr = wr_en && (address == ADDR_UPTIME);

  // Merge enabled byte lanes of new data over the current register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Uptime counter and coherent high-word snapshot
  // ---------------------------------------------------------------------------
  logic [63:0] uptime;
  logic [31:0] uptime_hi;

  // Free-running 64-bit cycle counter; a write to word 4 restarts it at zero.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
    end else if (uptime_clr) begin
      uptime <= '0;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // Capture the high word in the same edge the low word is read, so a
  // LO-then-HI read pair is consistent even if a carry happens in between.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_hi <= '0;
    end else if (uptime_rd) begin
      uptime_hi <= uptime[63:32];
    end
  end

  // ---------------------------------------------------------------------------
  // Scratch registers
  // ---------------------------------------------------------------------------
  logic [31:0] scratch0;
  logic [31:0] scratch1;

  if (NUM_SCRATCH > 0) begin : g_scratch0
    // Byte-writable scratch register 0.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        scratch0 <= SCRATCH_RESET;
      end else if (wr_en && (address == ADDR_SCRATCH0)) begin
        scratch0 <= merge_bytes(scratch0, writedata, byteenable);
      end
    end
  end else begin : g_no_scratch0
    assign scratch0 = '0;
  end

  if (NUM_SCRATCH > 1) begin : g_scratch1
    // Byte-writable scratch register 1.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        scratch1 <= SCRATCH_RESET;
      end else if (wr_en && (address == ADDR_SCRATCH1)) begin
        scratch1 <= merge_bytes(scratch1, writedata, byteenable);
      end
    end
  end else begin : g_no_scratch1
    assign scratch1 = '0;
  end

  // ---------------------------------------------------------------------------
  // Read mux and return pipeline
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  // Select the word addressed this cycle; the live low uptime word is taken
  // before the edge that increments it.
  // NOTE: rd_mux gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_STAMP:     rd_mux = TIMESTAMP;
      ADDR_VERSION:   rd_mux = VERSION;
      ADDR_CAPS:      rd_mux = CAPS;
      ADDR_UPTIME:    rd_mux = uptime[31:0];
      ADDR_UPTIME_HI: rd_mux = uptime_hi;
      ADDR_SCRATCH0:  rd_mux = scratch0;
      ADDR_SCRATCH1:  rd_mux = scratch1;
      default:        rd_mux = '0;
    endcase
  end

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];

  // Shift read strobes and data toward the output; a stage's data only moves
  // with a valid, so the last stage holds the previous return between strobes.
  // NOTE: the data stages are reset (unlike a plain storage array) because
  // the last one drives readdata, which must read zero out of reset; the
  // valid bits are reset so reads in flight at reset are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= read;
      if (read) dat_pipe[0] <= rd_mux;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign readdata      = dat_pipe[READ_LATENCY-1];
  assign readdatavalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_vectadd_sysid_ext.sv
// Directed bench for vectadd_sysid_ext. Two instances share the bus:
// dut_a (READ_LATENCY=2, NUM_SCRATCH=2) and dut_b (READ_LATENCY=3,
// NUM_SCRATCH=1). Inputs are driven and outputs sampled on falling edges.

module tb_vectadd_sysid_ext;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;

  int vectors     = 0;
  int miscompares = 0;

  vectadd_sysid_ext #(.READ_LATENCY(2), .NUM_SCRATCH(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(a_data), .readdatavalid(a_valid)
  );

  vectadd_sysid_ext #(.READ_LATENCY(3), .NUM_SCRATCH(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(b_data), .readdatavalid(b_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one read at the current falling edge and wait (bounded) for each
  // instance's strobe; latency is counted in falling edges, -1 on timeout.
  task automatic do_read(input logic [2:0] addr,
                         output logic [31:0] da, output logic [31:0] db,
                         output int la, output int lb);
    la = -1; lb = -1; da = 'x; db = 'x;
    address = addr; read = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      if (la < 0 && a_valid) begin la = i; da = a_data; end
      if (lb < 0 && b_valid) begin lb = i; db = b_data; end
      if (la >= 0 && lb >= 0) break;
    end
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    address = addr; writedata = data; byteenable = be; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if (a_data !== 32'd0 || a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a: got data=%h valid=%b expected data=0 valid=0", a_data, a_valid);
    end
    vectors++;
    if (b_data !== 32'd0 || b_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: got data=%h valid=%b expected data=0 valid=0", b_data, b_valid);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Back-to-back reads of words 0..3: continuous strobes at +L..+L+3 and
  // readdata holding the last word afterwards.
  task automatic test_id_words;
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    logic [31:0] ea, eb;
    logic        va, vb;
    exp_a = '{32'd0, 32'd1480046161, 32'h0002_0000, 32'h5359_0022};
    exp_b = '{32'd0, 32'd1480046161, 32'h0002_0000, 32'h5359_0013};
    for (int c = 0; c <= 8; c++) begin
      va = (c >= 2 && c <= 5);
      vb = (c >= 3 && c <= 6);
      ea = (c < 2) ? 32'd0 : (c <= 5) ? exp_a[c-2] : exp_a[3];
      eb = (c < 3) ? 32'd0 : (c <= 6) ? exp_b[c-3] : exp_b[3];
      vectors++;
      if (a_valid !== va || a_data !== ea) begin
        miscompares++;
        $display("FAIL id_a cycle %0d: got valid=%b data=%h expected valid=%b data=%h", c, a_valid, a_data, va, ea);
      end
      vectors++;
      if (b_valid !== vb || b_data !== eb) begin
        miscompares++;
        $display("FAIL id_b cycle %0d: got valid=%b data=%h expected valid=%b data=%h", c, b_valid, b_data, vb, eb);
      end
      if (c < 4) begin read = 1'b1; address = 3'(c); end
      else read = 1'b0;
      @(negedge clock);
    end
  endtask

  // Preload dut_a's counter just below a 32-bit carry; the HI snapshot must
  // follow the LO read, not the live counter.
  task automatic test_uptime_coherency;
    logic [31:0] da, db;
    int la, lb;
    force dut_a.uptime = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut_a.uptime;
    do_read(3'd4, da, db, la, lb);
    vectors++;
    if (la !== 2 || da !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL uptime_lo1: got lat=%0d data=%h expected lat=2 data=fffffffe", la, da);
    end
    repeat (3) @(negedge clock);
    do_read(3'd5, da, db, la, lb);
    vectors++;
    if (da !== 32'd0) begin
      miscompares++;
      $display("FAIL uptime_hi1: got %h expected 00000000", da);
    end
    do_read(3'd4, da, db, la, lb);
    vectors++;
    if (da !== 32'd7) begin
      miscompares++;
      $display("FAIL uptime_lo2: got %h expected 00000007", da);
    end
    do_read(3'd5, da, db, la, lb);
    vectors++;
    if (da !== 32'd1) begin
      miscompares++;
      $display("FAIL uptime_hi2: got %h expected 00000001", da);
    end
  endtask

  // Clear the counter at edge k, read the snapshot at k+1 and word 4 at k+3.
  task automatic test_counter_clear;
    logic [31:0] da, db;
    int la, lb;
    address = 3'd4; writedata = 32'hFFFF_FFFF; byteenable = 4'b0000; write = 1'b1;
    @(negedge clock);
    write = 1'b0; read = 1'b1; address = 3'd5;
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    vectors++;
    if (a_valid !== 1'b1 || a_data !== 32'd1) begin
      miscompares++;
      $display("FAIL clear_snapshot_a: got valid=%b data=%h expected valid=1 data=00000001", a_valid, a_data);
    end
    read = 1'b1; address = 3'd4;
    @(negedge clock);
    read = 1'b0;
    vectors++;
    if (a_valid !== 1'b0 || b_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_strobes: got a_valid=%b b_valid=%b expected a_valid=0 b_valid=1", a_valid, b_valid);
    end
    @(negedge clock);
    vectors++;
    if (a_valid !== 1'b1 || a_data !== 32'd2) begin
      miscompares++;
      $display("FAIL clear_value_a: got valid=%b data=%h expected valid=1 data=00000002", a_valid, a_data);
    end
    @(negedge clock);
    vectors++;
    if (b_valid !== 1'b1 || b_data !== 32'd2) begin
      miscompares++;
      $display("FAIL clear_value_b: got valid=%b data=%h expected valid=1 data=00000002", b_valid, b_data);
    end
    do_read(3'd5, da, db, la, lb);
    vectors++;
    if (da !== 32'd0 || db !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_snapshot_new: got a=%h b=%h expected 00000000", da, db);
    end
  endtask

  task automatic test_scratch;
    logic [31:0] da, db;
    int la, lb;
    do_write(3'd6, 32'hAABB_CCDD, 4'b1111);
    do_write(3'd6, 32'h1122_3344, 4'b0101);
    do_read(3'd6, da, db, la, lb);
    vectors++;
    if (da !== 32'hAA22_CC44 || db !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL scratch0_be: got a=%h b=%h expected aa22cc44", da, db);
    end
    do_write(3'd7, 32'hDEAD_BEEF, 4'b1111);
    do_read(3'd7, da, db, la, lb);
    vectors++;
    if (da !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL scratch1_a: got %h expected deadbeef", da);
    end
    vectors++;
    if (db !== 32'd0 || lb !== 3) begin
      miscompares++;
      $display("FAIL scratch1_absent_b: got lat=%0d data=%h expected lat=3 data=00000000", lb, db);
    end
    do_write(3'd2, 32'h0BAD_F00D, 4'b1111);
    do_read(3'd2, da, db, la, lb);
    vectors++;
    if (da !== 32'h0002_0000) begin
      miscompares++;
      $display("FAIL version_ro: got %h expected 00020000", da);
    end
  endtask

  task automatic test_rd_wr_collision;
    logic [31:0] da, db;
    int la, lb;
    writedata = 32'h1234_5678; byteenable = 4'b1111; write = 1'b1;
    do_read(3'd6, da, db, la, lb);
    vectors++;
    if (da !== 32'hAA22_CC44 || db !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL collision_read: got a=%h b=%h expected aa22cc44", da, db);
    end
    do_read(3'd6, da, db, la, lb);
    vectors++;
    if (da !== 32'hAA22_CC44 || db !== 32'hAA22_CC44) begin
      miscompares++;
      $display("FAIL collision_unchanged: got a=%h b=%h expected aa22cc44", da, db);
    end
  endtask

  // Reset with two reads in flight: no strobes, readdata back to zero, and
  // the pipeline works normally afterwards.
  task automatic test_reset_inflight;
    logic [31:0] da, db;
    int la, lb;
    read = 1'b1; address = 3'd1;
    @(negedge clock);
    address = 3'd2;
    @(negedge clock);
    read = 1'b0;
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0 || b_data !== 32'd0 || a_data !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_inflight %0d: got a_valid=%b b_valid=%b a=%h b=%h expected 0 0 0 0", c, a_valid, b_valid, a_data, b_data);
      end
      @(negedge clock);
      if (c == 1) reset_n = 1'b1;
    end
    do_read(3'd0, da, db, la, lb);
    vectors++;
    if (la !== 2 || lb !== 3 || da !== 32'd0 || db !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_read: got lat_a=%0d lat_b=%0d a=%h b=%h expected 2 3 0 0", la, lb, da, db);
    end
    do_read(3'd1, da, db, la, lb);
    vectors++;
    if (da !== 32'd1480046161 || db !== 32'd1480046161) begin
      miscompares++;
      $display("FAIL post_reset_stamp: got a=%h b=%h expected %h", da, db, 32'd1480046161);
    end
  endtask

  initial begin
    test_reset();
    test_id_words();
    test_uptime_coherency();
    test_counter_clear();
    test_scratch();
    test_rd_wr_collision();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
